// File: rtl/snn_pkg.sv
// snn_pkg: sequencer FSM states and spike-source selector encodings shared by the SNN core.
package snn_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_DRAIN, S_FIN} seq_state_t;
    localparam logic [1:0] SRC_PATTERN   = 2'b00;
    localparam logic [1:0] SRC_BERNOULLI = 2'b01;
    localparam logic [1:0] SRC_OR        = 2'b10;
    localparam logic [1:0] SRC_AND       = 2'b11;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: per-neuron spike counter that sticks at all-ones and flags the overflow.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             sat
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            if (&count) sat <= 1'b1;
            else count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/snn_core_sequencer.sv
// snn_core_sequencer: runs an SNN for sim_time timesteps, gates input spikes on the
// timestep strobe, counts output spikes per neuron and drains the counts to a RAM.
module snn_core_sequencer
    import snn_pkg::*;
#(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_OUTPUTS   = 4,
    parameter int TIMESTEP_BITS = 8,
    parameter int PERIOD_BITS   = 4,
    parameter int COUNT_WIDTH   = 32,
    parameter int OUT_ADDR_BITS = 4
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     accumulate,
    input  logic [1:0]               src_mode,
    input  logic [TIMESTEP_BITS-1:0] sim_time,
    input  logic [PERIOD_BITS-1:0]   ts_period,
    input  logic [NUM_INPUTS-1:0]    pattern_spikes,
    input  logic [NUM_INPUTS-1:0]    bernoulli_spikes,
    input  logic [NUM_OUTPUTS-1:0]   net_spikes,
    output logic [NUM_INPUTS-1:0]    spike_in,
    output logic                     ts_en,
    output logic [TIMESTEP_BITS-1:0] ts_cntr,
    output logic                     net_rst,
    output logic                     cnt_wen,
    output logic [OUT_ADDR_BITS-1:0] cnt_addr,
    output logic [COUNT_WIDTH-1:0]   cnt_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [NUM_OUTPUTS-1:0]   sat
);
    seq_state_t                 r_state, w_next;
    logic [PERIOD_BITS-1:0]     r_phase, r_period;
    logic [TIMESTEP_BITS-1:0]   r_ts_cntr, r_sim_time;
    logic [1:0]                 r_mode;
    logic                       r_acc, r_aborted;
    logic [OUT_ADDR_BITS-1:0]   r_addr;
    logic                       w_strobe, w_last, w_abort, w_accept, w_clr, w_cnt_en;
    logic [NUM_INPUTS-1:0]      w_mix;
    logic [COUNT_WIDTH-1:0]     w_rdata;
    logic [COUNT_WIDTH-1:0]     w_count [NUM_OUTPUTS];

    assign w_strobe = (r_state == S_RUN) && (r_phase == r_period);
    assign w_last   = r_addr == OUT_ADDR_BITS'(NUM_OUTPUTS - 1);
    assign w_abort  = abort && (r_state == S_CLEAR || r_state == S_RUN || r_state == S_SETTLE);
    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_clr    = (r_state == S_CLEAR) && !r_acc;
    assign w_cnt_en = (r_state == S_RUN) || (r_state == S_SETTLE);
    assign w_mix    = r_mode == SRC_PATTERN   ? pattern_spikes :
                      r_mode == SRC_BERNOULLI ? bernoulli_spikes :
                      r_mode == SRC_OR        ? (pattern_spikes | bernoulli_spikes) :
                                                (pattern_spikes & bernoulli_spikes);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_accept ? S_CLEAR : S_IDLE;
            S_CLEAR:  w_next = abort ? S_FIN : (r_sim_time == '0 ? S_SETTLE : S_RUN);
            S_RUN:    w_next = abort ? S_FIN :
                               (w_strobe && r_ts_cntr == r_sim_time - 1'b1) ? S_SETTLE : S_RUN;
            S_SETTLE: w_next = abort ? S_FIN : S_DRAIN;
            S_DRAIN:  w_next = w_last ? S_FIN : S_DRAIN;
            default:  w_next = S_IDLE;
        endcase
    end

    // Run configuration is captured when the start is accepted so CLEAR already sees it.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_period   <= '0;
            r_ts_cntr  <= '0;
            r_sim_time <= '0;
            r_mode     <= '0;
            r_acc      <= 1'b0;
            r_aborted  <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_state <= w_next;
            r_addr  <= (r_state == S_DRAIN && !w_last) ? r_addr + 1'b1 : '0;
            if (w_accept) begin
                r_mode     <= src_mode;
                r_sim_time <= sim_time;
                r_period   <= ts_period;
                r_acc      <= accumulate;
            end
            if (r_state == S_CLEAR) begin
                r_ts_cntr <= '0;
                r_phase   <= '0;
                r_aborted <= 1'b0;
            end
            if (r_state == S_RUN) begin
                r_phase <= w_strobe ? '0 : r_phase + 1'b1;
                if (w_strobe) r_ts_cntr <= r_ts_cntr + 1'b1;
            end
            if (w_abort) r_aborted <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
        sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt (
            .clk   (S_AXI_ACLK),
            .rst_n (S_AXI_ARESETN),
            .clr   (w_clr),
            .inc   (w_cnt_en && net_spikes[i]),
            .count (w_count[i]),
            .sat   (sat[i])
        );
    end

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++)
            if (r_addr == OUT_ADDR_BITS'(k)) w_rdata = w_count[k];
    end

    assign spike_in  = w_strobe ? w_mix : '0;
    assign ts_en     = w_strobe;
    assign ts_cntr   = r_ts_cntr;
    assign net_rst   = r_state == S_CLEAR;
    assign cnt_wen   = r_state == S_DRAIN;
    assign cnt_addr  = r_addr;
    assign cnt_wdata = cnt_wen ? w_rdata : '0;
    assign busy      = r_state != S_IDLE;
    assign done      = r_state == S_FIN;
    assign aborted   = r_aborted;
endmodule
